hdownscale2_stage: RTL

//  Streaming 2:1 horizontal downscaler between the DRAM reader output (64b valid/ready) and the

---
 rtl/hdownscale2_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/hdownscale2_stage.sv
// 2:1 horizontal downscaler: averages adjacent 8-bit pixel pairs, two 64b input words per 64b output word.
module hdownscale2_stage #(
  parameter bit          ROUND = 1'b1,
  parameter int unsigned CNT_W = 32
) (
  input  logic             fclk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic [CNT_W-1:0] frame_words,
  input  logic [63:0]      din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [63:0]      dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned HALF_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_remaining;
  logic               r_half_valid;
  logic [HALF_W-1:0]  r_half;
  logic [63:0]        r_dout;
  logic               r_dout_valid;
  logic               r_frame_done;

  logic               w_out_free;
  logic               w_fire_in;
  logic               w_last;
  logic [HALF_W-1:0]  w_avg;

  // Four pair averages of one input word; 9-bit sum so 0xFF+0xFF+1 cannot overflow.
  function automatic logic [HALF_W-1:0] avg4(input logic [63:0] w);
    logic [8:0]        s;
    logic [HALF_W-1:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      s = 9'(w[16*k +: PIX_W]) + 9'(w[16*k+8 +: PIX_W]) + 9'(ROUND);
      r[PIX_W*k +: PIX_W] = s[8:1];
    end
    return r;
  endfunction

  // Output register can take new data this cycle (empty or being drained).
  assign w_out_free = !r_dout_valid || dout_ready;
  assign w_fire_in  = din_valid && din_ready;
  assign w_last     = (r_remaining == CNT_W'(1));
  assign w_avg      = avg4(din);

  // First word of a pair only fills the half buffer, so it never waits on the output.
  assign din_ready  = (r_state == S_RUN) && (!r_half_valid || w_out_free);
  assign busy       = (r_state != S_IDLE);
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign frame_done = r_frame_done;

  // Frame FSM, pair assembly and registered output stage.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_remaining  <= '0;
      r_half_valid <= 1'b0;
      r_half       <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            if (frame_words != '0) begin
              r_state      <= S_RUN;
              r_remaining  <= frame_words;
              r_half_valid <= 1'b0;
            end else begin
              r_frame_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_fire_in) begin
            r_remaining <= r_remaining - CNT_W'(1);
            if (r_half_valid) begin
              r_dout       <= {w_avg, r_half};
              r_dout_valid <= 1'b1;
              r_half_valid <= 1'b0;
            end else if (w_last && w_out_free) begin
              r_dout       <= {HALF_W'(0), w_avg};
              r_dout_valid <= 1'b1;
            end else begin
              // Odd tail with a stalled output parks here and is padded out in FLUSH.
              r_half       <= w_avg;
              r_half_valid <= 1'b1;
            end
            if (w_last) begin
              r_state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (r_half_valid) begin
            if (w_out_free) begin
              r_dout       <= {HALF_W'(0), r_half};
              r_dout_valid <= 1'b1;
              r_half_valid <= 1'b0;
            end
          end else if (w_out_free) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
